ecsu_param: RTL and testbench
=============================

ECSU_PARAM -- requirements
Module: ecsu_param

Interface
REQ-001 Parameter WIND_W, 6, wind input width in bits.
REQ-002 Parameter TEMP_W, 8, signed temperature width in bits.
REQ-003 Parameter CAUTION_WIND, 10, wind above this value is a caution condition.
REQ-004 Parameter HIGH_WIND, 15, wind above this value is a severe condition.
REQ-005 Parameter EMERG_WIND, 20, wind above this value is an emergency condition.
REQ-006 Parameter TEMP_HIGH, 35, |temperature| above this value is a severe condition.
REQ-007 Parameter TEMP_EMERG, 40, |temperature| above this value is an emergency condition.
REQ-008 Parameter DWELL, 4, consecutive clean cycles required before any de-escalation.
REQ-009 CLK  in  1  single clock, all state updated on rising edge.
REQ-010 RST  in  1  reset, synchronous, active-low.
REQ-011 thunderstorm  in  1  thunderstorm present.
REQ-012 wind  in  WIND_W  unsigned wind speed.
REQ-013 visibility  in  2  00 clear, 01 reduced, 10 reserved (treated as clear), 11 zero.
REQ-014 temperature  in  TEMP_W  signed two's-complement temperature.
REQ-015 ack  in  1  operator acknowledge of emergency.
REQ-016 ECSU_state  out  2  current state.
REQ-017 severe_weather  out  1  high in HIGH_ALERT or EMERGENCY.
REQ-018 emergency_landing_alert  out  1  high in EMERGENCY.
REQ-019 state_change  out  1  one-cycle pulse on the cycle after any state transition.

Function
REQ-020 Encoding SHALL be ALL_CLEAR=00, CAUTION=01, HIGH_ALERT=10, EMERGENCY=11.
REQ-021 sev SHALL be thunderstorm | wind>HIGH_WIND | visibility==11 | temperature>TEMP_HIGH | temperature<-TEMP_HIGH, using signed compares.
REQ-022 caut SHALL be !sev & (wind>CAUTION_WIND | visibility==01).
REQ-023 emerg SHALL be wind>EMERG_WIND | temperature>TEMP_EMERG | temperature<-TEMP_EMERG.
REQ-024 Inputs sampled at edge k SHALL determine state and outputs visible after edge k (one-cycle latency); all outputs registered, no combinational input-to-output path.
REQ-025 ALL_CLEAR: emerg or sev -> HIGH_ALERT; else caut -> CAUTION; else stay.
REQ-026 CAUTION: emerg or sev -> HIGH_ALERT immediately; !caut & !sev for DWELL consecutive samples -> ALL_CLEAR.
REQ-027 HIGH_ALERT: emerg -> EMERGENCY immediately; !sev for DWELL consecutive samples -> CAUTION.
REQ-028 EMERGENCY: ack & !emerg & !sev -> HIGH_ALERT; no other exit; ack is ignored in all other states.
REQ-029 Escalation SHALL take priority over de-escalation when both qualify on the same sample.
REQ-030 Dwell counter SHALL clear on every state transition and on any sample failing the current state's clean condition, and SHALL saturate at DWELL.
REQ-031 Dwell counter width SHALL be clog2(DWELL+1); DWELL>=1; CAUTION_WIND<HIGH_WIND<EMERG_WIND and TEMP_HIGH<TEMP_EMERG SHALL be checked at elaboration.
REQ-032 Boundary values SHALL be non-triggering: wind==HIGH_WIND is not sev, temperature==-TEMP_HIGH is not sev.
REQ-033 severe_weather and emergency_landing_alert SHALL be decoded from the registered next state, never latched independently.

Reset
REQ-034 RST low at a rising edge SHALL force ECSU_state=ALL_CLEAR, dwell counter=0, severe_weather=0, emergency_landing_alert=0, state_change=0, overriding any transition in progress, including EMERGENCY.

Structure
REQ-035 State encodings and the state typedef SHALL reside in shared package ecsu_pkg.
REQ-036 Dwell counting SHALL be a sub-module ecsu_dwell_counter (inputs clear, count_en; output done).

Verification
REQ-037 Reset, then wind=12, visibility=00 -> CAUTION after 1 edge, state_change=1 for one cycle.
REQ-038 In CAUTION, wind=5 for 3 cycles, wind=12 once, wind=5 for 4 cycles -> ALL_CLEAR exactly on the 4th clean edge after the interruption.
REQ-039 In ALL_CLEAR, temperature=-41 -> HIGH_ALERT next edge, EMERGENCY the following edge, emergency_landing_alert=1.
REQ-040 In EMERGENCY, ack=1 with wind=22 -> stays EMERGENCY; ack=1 with wind=5, temperature=20 -> HIGH_ALERT next edge, severe_weather stays 1.
REQ-041 wind=15, temperature=-35 from ALL_CLEAR -> CAUTION (not HIGH_ALERT).
REQ-042 In EMERGENCY, RST=0 for one edge -> all outputs 0, ECSU_state=00; then with RST=1 and thunderstorm=1 -> HIGH_ALERT next edge.

Source files
------------

// File: rtl/ecsu_pkg.sv
// rtl/ecsu_pkg.sv - shared state encoding for the ECSU weather-alert controller
package ecsu_pkg;

  typedef enum logic [1:0] {
    ALL_CLEAR  = 2'b00,
    CAUTION    = 2'b01,
    HIGH_ALERT = 2'b10,
    EMERGENCY  = 2'b11
  } ecsu_state_t;

  localparam logic [1:0] VIS_REDUCED = 2'b01;
  localparam logic [1:0] VIS_ZERO    = 2'b11;

endpackage

// File: rtl/ecsu_dwell_counter.sv
// rtl/ecsu_dwell_counter.sv - saturating count of consecutive clean samples
module ecsu_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_done
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && (r_cnt != L_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Asserted on the sample that would be the DWELL-th clean one in a row.
  assign o_done = i_count_en && (r_cnt >= L_LAST);

endmodule

// File: rtl/ecsu_param.sv
// rtl/ecsu_param.sv - weather alert state machine with dwell-qualified de-escalation
module ecsu_param
  import ecsu_pkg::*;
#(
  parameter int WIND_W       = 6,
  parameter int TEMP_W       = 8,
  parameter int CAUTION_WIND = 10,
  parameter int HIGH_WIND    = 15,
  parameter int EMERG_WIND   = 20,
  parameter int TEMP_HIGH    = 35,
  parameter int TEMP_EMERG   = 40,
  parameter int DWELL        = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_thunderstorm,
  input  logic [WIND_W-1:0] i_wind,
  input  logic [1:0]        i_visibility,
  input  logic [TEMP_W-1:0] i_temperature,
  input  logic              i_ack,
  output logic [1:0]        o_ecsu_state,
  output logic              o_severe_weather,
  output logic              o_emergency_landing_alert,
  output logic              o_state_change
);

  if ((DWELL < 1) || !(CAUTION_WIND < HIGH_WIND && HIGH_WIND < EMERG_WIND) ||
      !(TEMP_HIGH < TEMP_EMERG)) begin : g_param_check
    $error("ecsu_param: illegal threshold or dwell parameters");
  end

  localparam logic [WIND_W-1:0]        L_CAUT_W  = WIND_W'(CAUTION_WIND);
  localparam logic [WIND_W-1:0]        L_HIGH_W  = WIND_W'(HIGH_WIND);
  localparam logic [WIND_W-1:0]        L_EMERG_W = WIND_W'(EMERG_WIND);
  localparam logic signed [TEMP_W-1:0] L_T_HI    = TEMP_W'(TEMP_HIGH);
  localparam logic signed [TEMP_W-1:0] L_T_HI_N  = TEMP_W'(-TEMP_HIGH);
  localparam logic signed [TEMP_W-1:0] L_T_EM    = TEMP_W'(TEMP_EMERG);
  localparam logic signed [TEMP_W-1:0] L_T_EM_N  = TEMP_W'(-TEMP_EMERG);

  ecsu_state_t r_state;
  ecsu_state_t w_next;
  logic        r_state_change;
  logic        w_sev, w_caut, w_emerg, w_clean, w_done, w_clear;
  logic signed [TEMP_W-1:0] w_temp;

  assign w_temp  = $signed(i_temperature);
  assign w_sev   = i_thunderstorm || (i_wind > L_HIGH_W) || (i_visibility == VIS_ZERO) ||
                   (w_temp > L_T_HI) || (w_temp < L_T_HI_N);
  assign w_caut  = !w_sev && ((i_wind > L_CAUT_W) || (i_visibility == VIS_REDUCED));
  assign w_emerg = (i_wind > L_EMERG_W) || (w_temp > L_T_EM) || (w_temp < L_T_EM_N);

  // What counts as a clean sample depends on the state being left.
  always_comb begin
    w_clean = 1'b0;
    case (r_state)
      ALL_CLEAR, CAUTION: w_clean = !w_caut && !w_sev;
      HIGH_ALERT:         w_clean = !w_sev;
      default:            w_clean = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ALL_CLEAR: begin
        if (w_emerg || w_sev)   w_next = HIGH_ALERT;
        else if (w_caut)        w_next = CAUTION;
      end
      CAUTION: begin
        if (w_emerg || w_sev)   w_next = HIGH_ALERT;
        else if (w_done)        w_next = ALL_CLEAR;
      end
      HIGH_ALERT: begin
        if (w_emerg)            w_next = EMERGENCY;
        else if (w_done)        w_next = CAUTION;
      end
      EMERGENCY: begin
        if (i_ack && !w_emerg && !w_sev) w_next = HIGH_ALERT;
      end
      default:                  w_next = ALL_CLEAR;
    endcase
  end

  assign w_clear = !w_clean || (w_next != r_state);

  ecsu_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_clear),
    .i_count_en (w_clean),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= ALL_CLEAR;
      r_state_change <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_state_change <= (w_next != r_state);
    end
  end

  assign o_ecsu_state              = r_state;
  assign o_severe_weather          = (r_state == HIGH_ALERT) || (r_state == EMERGENCY);
  assign o_emergency_landing_alert = (r_state == EMERGENCY);
  assign o_state_change            = r_state_change;

endmodule

// File: tb/tb_ecsu_param.sv
// tb/tb_ecsu_param.sv - table-driven scoreboard bench for ecsu_param
module tb_ecsu_param;

  typedef struct {
    logic              rst_n;
    logic              th;
    logic [5:0]        wind;
    logic [1:0]        vis;
    logic signed [7:0] temp;
    logic              ack;
    logic [1:0]        st;
    logic              sev;
    logic              em;
    logic              chg;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] st;
    logic       sev;
    logic       em;
    logic       chg;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              th = 1'b0;
  logic [5:0]        wind = '0;
  logic [1:0]        vis = '0;
  logic signed [7:0] temp = '0;
  logic              ack = 1'b0;
  logic [1:0]        st;
  logic              sev, em, chg;

  int   tests = 0;
  int   fails = 0;
  int   step  = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  ecsu_param dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_thunderstorm            (th),
    .i_wind                    (wind),
    .i_visibility              (vis),
    .i_temperature             (temp),
    .i_ack                     (ack),
    .o_ecsu_state              (st),
    .o_severe_weather          (sev),
    .o_emergency_landing_alert (em),
    .o_state_change            (chg)
  );

  function automatic vec_t mk(input logic r, input logic t, input int w, input int v,
                              input int tp, input logic a, input int s,
                              input logic sv, input logic e, input logic c);
    vec_t x;
    x.rst_n = r; x.th = t; x.wind = 6'(w); x.vis = 2'(v); x.temp = 8'(tp);
    x.ack = a; x.st = 2'(s); x.sev = sv; x.em = e; x.chg = c;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; th = v.th; wind = v.wind; vis = v.vis; temp = v.temp; ack = v.ack;
    e.idx = step; e.st = v.st; e.sev = v.sev; e.em = v.em; e.chg = v.chg;
    sb.push_back(e);
    step++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", step, 0, 1);
    end else begin
      e = sb.pop_front();
      chk("state", e.idx, int'(st), int'(e.st));
      chk("severe_weather", e.idx, int'(sev), int'(e.sev));
      chk("emergency_alert", e.idx, int'(em), int'(e.em));
      chk("state_change", e.idx, int'(chg), int'(e.chg));
    end
  endtask

  initial begin
    // rst th wind vis temp ack | state sev em chg
    tbl.push_back(mk(0,0, 0,0,  0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,12,0,  0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,12,0,  0,0, 1,0,0,1));
    tbl.push_back(mk(1,0, 5,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 5,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 5,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,12,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 5,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 5,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 5,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 5,0,  0,0, 0,0,0,1));
    tbl.push_back(mk(1,0, 5,0,  0,0, 0,0,0,0));
    tbl.push_back(mk(1,0, 0,0,-41,0, 2,1,0,1));
    tbl.push_back(mk(1,0, 0,0,-41,0, 3,1,1,1));
    tbl.push_back(mk(1,0,22,0,  0,1, 3,1,1,0));
    tbl.push_back(mk(1,0, 5,0, 20,1, 2,1,0,1));
    tbl.push_back(mk(1,0, 5,0, 20,0, 2,1,0,0));
    tbl.push_back(mk(1,0, 5,0, 20,1, 2,1,0,0));
    tbl.push_back(mk(1,0, 5,0, 20,0, 2,1,0,0));
    tbl.push_back(mk(1,0, 5,0, 20,0, 1,0,0,1));
    tbl.push_back(mk(1,0, 0,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 0,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 0,0,  0,0, 1,0,0,0));
    tbl.push_back(mk(1,0, 0,0,  0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,15,0,-35,0, 1,0,0,1));
    tbl.push_back(mk(1,0,16,0,  0,0, 2,1,0,1));
    tbl.push_back(mk(1,0, 0,3,  0,0, 2,1,0,0));
    tbl.push_back(mk(1,0,21,0,  0,0, 3,1,1,1));
    tbl.push_back(mk(0,0,21,0,  0,0, 0,0,0,0));
    tbl.push_back(mk(1,1, 0,0,  0,0, 2,1,0,1));
    tbl.push_back(mk(1,0, 0,0, 40,0, 2,1,0,0));
    tbl.push_back(mk(1,0,20,0,  0,0, 2,1,0,0));
    tbl.push_back(mk(1,0, 0,0, 41,0, 3,1,1,1));
    tbl.push_back(mk(0,0, 0,0,  0,0, 0,0,0,0));
    tbl.push_back(mk(1,0, 0,2,  0,0, 0,0,0,0));
    tbl.push_back(mk(1,0, 0,1,  0,0, 1,0,0,1));
    tbl.push_back(mk(1,0, 0,0, 36,0, 2,1,0,1));

    foreach (tbl[i]) apply(tbl[i]);

    // Emergency exit needs ack with a fully clean sample; nothing else leaves it.
    apply(mk(0,0, 0,0,  0,0, 0,0,0,0));
    apply(mk(1,1, 0,0,  0,0, 2,1,0,1));
    apply(mk(1,0,21,0,  0,0, 3,1,1,1));
    apply(mk(1,1, 0,0,  0,1, 3,1,1,0));
    apply(mk(1,0, 0,0,  0,0, 3,1,1,0));
    apply(mk(1,0,16,0,  0,1, 3,1,1,0));
    apply(mk(1,0, 0,0,  0,1, 2,1,0,1));

    // Escalation wins over a dwell that is one sample from completing.
    apply(mk(1,0, 0,0,  0,0, 2,1,0,0));
    apply(mk(1,0, 0,0,  0,0, 2,1,0,0));
    apply(mk(1,0, 0,0,  0,0, 2,1,0,0));
    apply(mk(1,0,21,0,  0,0, 3,1,1,1));

    if (sb.size() != 0) chk("scoreboard_drain", step, sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog step %0d: got timeout expected completion", step);
    $fatal(1, "watchdog");
  end

endmodule
